tube_event_builder: RTL

TUBE_EVENT_BUILDER -- requirements
Module: tube_event_builder

---
 rtl/tube_event_builder_if.sv | 17 +
 rtl/tube_event_builder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/tube_event_builder_if.sv
// rtl/tube_event_builder_if.sv - write-side bus between the event builder and the readout FIFO
//
// Signals:
//   WR_DATA  16-bit event word offered to the FIFO
//   WR_EN    write strobe, one word transferred per cycle it is high
//   WR_FULL  FIFO full flag; while high no word is accepted
// Modports:
//   master   event builder side (drives WR_DATA/WR_EN, observes WR_FULL)
//   slave    FIFO side (observes WR_DATA/WR_EN, drives WR_FULL)
interface tube_event_builder_if;
    logic [15:0] WR_DATA;
    logic        WR_EN;
    logic        WR_FULL;

    modport master (output WR_DATA, output WR_EN, input WR_FULL);
    modport slave  (input WR_DATA, input WR_EN, output WR_FULL);
endinterface

// File: rtl/tube_event_builder.sv
// rtl/tube_event_builder.sv - drift-tube event builder: trigger window, first-hit capture, FIFO readout
//
// Collects first-hit arrival times on 32 drift-tube channels during a fixed
// window opened by a scintillator coincidence, then writes a header word, one
// word per hit channel in ascending channel order, and a trailer word.
//
// Ports:
//   clk100         100 MHz clock, all logic on its rising edge
//   reset          synchronous active-high reset
//   SCIN_COIN      asynchronous trigger input
//   TUBE3A..TUBE4B asynchronous hit inputs, channels 0-7, 8-15, 16-23, 24-31
//   wr             FIFO write bus (WR_DATA, WR_EN out; WR_FULL in)
//   overflowLight  sticky: a trigger arrived while an event was in progress
//   busy           high whenever the builder is not idle
module tube_event_builder #(
    parameter int WINDOW_CYCLES = 400
) (
    input  logic                    clk100,
    input  logic                    reset,
    input  logic                    SCIN_COIN,
    input  logic [7:0]              TUBE3A,
    input  logic [7:0]              TUBE3B,
    input  logic [7:0]              TUBE4A,
    input  logic [7:0]              TUBE4B,
    tube_event_builder_if.master    wr,
    output logic                    overflowLight,
    output logic                    busy
);

    localparam logic [9:0] LP_LAST = 10'(WINDOW_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WINDOW,
        S_HEADER,
        S_SCAN,
        S_TRAILER
    } state_t;

    // Bit 32 carries the trigger, bits 31:0 the tube channels.
    logic [32:0] w_raw;
    logic [32:0] r_sync1;
    logic [32:0] r_sync2;
    logic [32:0] r_prev;
    logic [32:0] r_edge;

    logic        w_trig;
    logic [31:0] w_tube_edge;
    logic [31:0] w_new_hits;

    state_t      r_state;
    state_t      w_next;

    logic [9:0]  r_count;
    logic [31:0] r_flags;
    logic [9:0]  r_times [32];
    logic [5:0]  r_nhits;
    logic [4:0]  r_scan;
    logic [13:0] r_event_count;
    logic        r_overflow;

    logic        w_pending;
    logic [15:0] w_wr_data;
    logic        w_advance;

    assign w_raw       = {SCIN_COIN, TUBE4B, TUBE4A, TUBE3B, TUBE3A};
    assign w_trig      = r_edge[32];
    assign w_tube_edge = r_edge[31:0];
    assign w_new_hits  = w_tube_edge & ~r_flags;

    // Synchronizers and registered rising-edge detectors for all 33 inputs.
    always_ff @(posedge clk100) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_edge  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and the word currently offered to the FIFO. A word is
    // presented combinationally from the state and scan position, so holding
    // the state during a stall holds WR_DATA.
    always_comb begin
        w_next    = r_state;
        w_pending = 1'b0;
        w_wr_data = 16'h0000;
        case (r_state)
            S_IDLE: begin
                if (w_trig) begin
                    w_next = S_WINDOW;
                end
            end
            S_WINDOW: begin
                if (r_count == LP_LAST) begin
                    w_next = S_HEADER;
                end
            end
            S_HEADER: begin
                w_pending = 1'b1;
                w_wr_data = {2'b10, r_event_count};
                if (!wr.WR_FULL) begin
                    w_next = S_SCAN;
                end
            end
            S_SCAN: begin
                w_pending = r_flags[r_scan];
                if (r_flags[r_scan]) begin
                    w_wr_data = {1'b0, r_scan, r_times[r_scan]};
                end
                if (!(w_pending && wr.WR_FULL) && (r_scan == 5'd31)) begin
                    w_next = S_TRAILER;
                end
            end
            S_TRAILER: begin
                w_pending = 1'b1;
                w_wr_data = {2'b11, r_nhits, 8'h00};
                if (!wr.WR_FULL) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Scan moves on unless a real word is waiting on a full FIFO.
    assign w_advance = !(w_pending && wr.WR_FULL);

    always_ff @(posedge clk100) begin
        if (reset) begin
            r_count       <= '0;
            r_flags       <= '0;
            r_nhits       <= '0;
            r_scan        <= '0;
            r_event_count <= '0;
            r_overflow    <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_times[i] <= '0;
            end
        end else begin
            if (w_trig && (r_state != S_IDLE)) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_trig) begin
                        r_count <= '0;
                        r_nhits <= '0;
                        r_scan  <= '0;
                    end
                end
                S_WINDOW: begin
                    r_count <= r_count + 10'd1;
                    r_flags <= r_flags | w_new_hits;
                    r_nhits <= r_nhits + 6'($countones(w_new_hits));
                    for (int i = 0; i < 32; i++) begin
                        if (w_new_hits[i]) begin
                            r_times[i] <= r_count;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_advance) begin
                        r_scan <= r_scan + 5'd1;
                    end
                end
                S_TRAILER: begin
                    if (!wr.WR_FULL) begin
                        r_flags       <= '0;
                        r_event_count <= r_event_count + 14'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign wr.WR_DATA    = w_wr_data;
    assign wr.WR_EN      = w_pending && !wr.WR_FULL;
    assign busy          = (r_state != S_IDLE);
    assign overflowLight = r_overflow;

endmodule
